fml_bram: RTL and testbench

- FML slave (responder) that terminates the 16-bit FML bus with on-chip block RAM.
- Serves 8-beat read and write bursts; sits on the slave side of the FML arbiter (s_* bus).
- Used for small fast-memory regions and as a stand-in for the SDRAM controller in simulation.

---
 rtl/fml_bram_pkg.sv | 19 +
 rtl/fml_bram_mem.sv | 32 +++
 rtl/fml_bram.sv | 98 +++++++++
 tb/tb_fml_bram.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fml_bram_pkg.sv
// Shared FML burst constants and the slave FSM state type.
// The burst constants are also used by the arbiter's write-burst counter.
package fml_bram_pkg;

  localparam int FML_BURST_LEN = 8;
  localparam int FML_BEAT_W    = 3;
  localparam int FML_DW        = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } fml_state_e;

  function automatic logic last_beat(input logic [FML_BEAT_W-1:0] beat);
    return beat == FML_BEAT_W'(FML_BURST_LEN - 1);
  endfunction

endpackage

// File: rtl/fml_bram_mem.sv
// Single-port synchronous RAM with byte-lane write enables and a registered read port.
// A read and a write to the same word in the same cycle returns the old contents.
module fml_bram_mem
  import fml_bram_pkg::*;
#(
  parameter int mem_depth = 11
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 re,
  input  logic [1:0]           we,
  input  logic [mem_depth-1:0] adr,
  input  logic [FML_DW-1:0]    di,
  output logic [FML_DW-1:0]    rdata
);

  logic [FML_DW-1:0] ram [2**mem_depth];

  always_ff @(posedge sys_clk) begin
    if (we[0]) ram[adr][7:0]  <= di[7:0];
    if (we[1]) ram[adr][15:8] <= di[15:8];
  end

  // The output register is the only part cleared by reset; the array keeps its contents.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      rdata <= '0;
    else if (re)
      rdata <= ram[adr];
  end

endmodule

// File: rtl/fml_bram.sv
// FML slave that serves 8-beat read and write bursts from on-chip block RAM.
// Beat 0 of a burst is handled in the ack cycle, so the next ack can come 8 cycles later.
module fml_bram
  import fml_bram_pkg::*;
#(
  parameter int fml_depth = 25,
  parameter int mem_depth = 11
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [fml_depth-1:0] fml_adr,
  input  logic                 fml_stb,
  input  logic                 fml_we,
  output logic                 fml_ack,
  input  logic [1:0]           fml_sel,
  input  logic [FML_DW-1:0]    fml_di,
  output logic [FML_DW-1:0]    fml_do
);

  localparam int BURST_AW = mem_depth - FML_BEAT_W;

  fml_state_e            state, state_next;
  logic [FML_BEAT_W-1:0] beat, beat_next;
  logic [BURST_AW-1:0]   burst_adr;
  logic [1:0]            mem_we;
  logic                  mem_re;
  logic [mem_depth-1:0]  mem_adr;
  logic                  adr_unused;

  // Address bits above the memory alias; the low nibble is the byte offset within the burst.
  assign adr_unused = ^{fml_adr[fml_depth-1:mem_depth+1], fml_adr[3:0]};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      beat      <= '0;
      burst_adr <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
      if (state == IDLE && fml_stb)
        burst_adr <= fml_adr[mem_depth:4];
    end
  end

  always_comb begin
    state_next = state;
    beat_next  = beat;
    fml_ack    = 1'b0;
    mem_we     = 2'b00;
    mem_re     = 1'b0;
    mem_adr    = {burst_adr, beat};
    case (state)
      IDLE: begin
        mem_adr = {fml_adr[mem_depth:4], {FML_BEAT_W{1'b0}}};
        if (fml_stb) begin
          fml_ack    = 1'b1;
          beat_next  = FML_BEAT_W'(1);
          mem_we     = fml_we ? fml_sel : 2'b00;
          mem_re     = !fml_we;
          state_next = fml_we ? WRITE : READ;
        end
      end
      WRITE: begin
        mem_we    = fml_sel;
        beat_next = beat + FML_BEAT_W'(1);
        if (last_beat(beat))
          state_next = IDLE;
      end
      READ: begin
        mem_re    = 1'b1;
        beat_next = beat + FML_BEAT_W'(1);
        if (last_beat(beat))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A reset cycle abandons the burst: no ack and no RAM write on that edge.
    if (sys_rst) begin
      fml_ack = 1'b0;
      mem_we  = 2'b00;
      mem_re  = 1'b0;
    end
  end

  fml_bram_mem #(
    .mem_depth(mem_depth)
  ) mem (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .re     (mem_re),
    .we     (mem_we),
    .adr    (mem_adr),
    .di     (fml_di),
    .rdata  (fml_do)
  );

endmodule

// File: tb/tb_fml_bram.sv
// Self-checking bench for fml_bram: a word-level memory model checked every cycle,
// plus directed bursts whose read-back data is compared with hand-computed values.
module tb_fml_bram;

  localparam int MEM_DEPTH = 11;
  localparam int MEM_WORDS = 2048;
  localparam logic [15:0] SEL_ALL = 16'hFFFF;

  logic        sys_clk, sys_rst;
  logic [24:0] fml_adr;
  logic        fml_stb, fml_we, fml_ack;
  logic [1:0]  fml_sel;
  logic [15:0] fml_di, fml_do;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [15:0] do_at [0:1023];
  logic [15:0] mm [0:MEM_WORDS-1];
  bit   [1:0]  mv [0:MEM_WORDS-1];
  bit          rst_seen = 1'b0;
  bit          do_known = 1'b0;
  logic [15:0] exp_do;
  int          busy_until = 0;
  int          wr_left = 0, rd_left = 0, burst_base = 0, burst_beat = 0;

  fml_bram #(
    .fml_depth(25),
    .mem_depth(MEM_DEPTH)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .fml_adr(fml_adr),
    .fml_stb(fml_stb),
    .fml_we (fml_we),
    .fml_ack(fml_ack),
    .fml_sel(fml_sel),
    .fml_di (fml_di),
    .fml_do (fml_do)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual === expected)
      n_pass++;
    else
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
  endtask

  // Model: a request is accepted whenever the slave is not inside a previous 8-cycle burst;
  // beat b of a burst acked at cycle T touches word ((adr/16)*8 + b) mod size at cycle T+b.
  always @(negedge sys_clk) begin : compare
    logic exp_ack;
    int   idx;
    if (sys_rst) rst_seen = 1'b1;
    exp_ack = fml_stb && !sys_rst && (cyc >= busy_until);
    if (cyc < 1024) do_at[cyc] = fml_do;
    if (rst_seen) checkOutput("model ack", {15'd0, fml_ack}, {15'd0, exp_ack});
    if (do_known) checkOutput("model fml_do", fml_do, exp_do);
    if (sys_rst) begin
      busy_until = cyc + 1;
      wr_left    = 0;
      rd_left    = 0;
      exp_do     = 16'h0000;
      do_known   = 1'b1;
    end else begin
      if (exp_ack) begin
        busy_until = cyc + 8;
        burst_base = int'(fml_adr >> 4);
        burst_beat = 0;
        if (fml_we) wr_left = 8;
        else        rd_left = 8;
      end
      idx = (burst_base * 8 + burst_beat) % MEM_WORDS;
      if (wr_left > 0) begin
        if (fml_sel[0]) begin mm[idx][7:0]  = fml_di[7:0];  mv[idx][0] = 1'b1; end
        if (fml_sel[1]) begin mm[idx][15:8] = fml_di[15:8]; mv[idx][1] = 1'b1; end
        burst_beat++;
        wr_left--;
      end else if (rd_left > 0) begin
        exp_do     = mm[idx];
        do_known   = (mv[idx] == 2'b11);
        burst_beat++;
        rd_left--;
      end
    end
  end

  task automatic applyStimulus(input logic stb, input logic we, input logic [24:0] adr,
                               input logic [1:0] sel, input logic [15:0] di);
    fml_stb = stb;
    fml_we  = we;
    fml_adr = adr;
    fml_sel = sel;
    fml_di  = di;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 25'h0, 2'b00, 16'h0);
  endtask

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle();
    @(negedge sys_clk);
    next_cycle();
  endtask

  task automatic request(input logic we, input logic [24:0] adr, input logic [1:0] sel,
                         input logic [15:0] di, output int t);
    t = -1;
    applyStimulus(1'b1, we, adr, sel, di);
    for (int i = 0; i < 16; i++) begin
      @(negedge sys_clk);
      if (fml_ack === 1'b1) begin
        t = cyc;
        break;
      end
      next_cycle();
    end
    if (t < 0) begin
      checkOutput("ack wait", {15'd0, fml_ack}, 16'd1);
      idle();
    end
  endtask

  // Returns at the start of cycle T+8 so another request can be acked back-to-back.
  task automatic write_burst(input logic [24:0] adr, input logic [127:0] d,
                             input logic [15:0] s, output int t);
    request(1'b1, adr, s[1:0], d[15:0], t);
    if (t >= 0) begin
      for (int b = 1; b < 8; b++) begin
        next_cycle();
        applyStimulus(1'b0, 1'b0, 25'h0, s[2*b +: 2], d[16*b +: 16]);
      end
      next_cycle();
      idle();
    end
  endtask

  task automatic read_burst(input logic [24:0] adr, output int t);
    request(1'b0, adr, 2'b00, 16'h0, t);
    if (t >= 0) begin
      next_cycle();
      idle();
      repeat (7) next_cycle();
    end
  endtask

  task automatic check_read(input int t, input logic [127:0] expected, input string name);
    if (t >= 0 && t + 8 < 1024)
      for (int b = 0; b < 8; b++)
        checkOutput(name, do_at[t + 1 + b], expected[16*b +: 16]);
  endtask

  function automatic logic [127:0] ramp(input logic [15:0] base);
    logic [127:0] r;
    for (int b = 0; b < 8; b++) r[16*b +: 16] = base + 16'(b);
    return r;
  endfunction

  initial begin : stimulus
    int t_rel, t1, t2, t3, t4, t5;
    logic [127:0] lanes;

    sys_rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 25'h0, 2'b00, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      checkOutput("reset ack", {15'd0, fml_ack}, 16'd0);
      checkOutput("reset do", fml_do, 16'h0000);
      next_cycle();
    end
    sys_rst = 1'b0;
    t_rel = cyc;

    write_burst(25'h100, ramp(16'h1110), SEL_ALL, t1);
    checkOutput("ack after reset", 16'(t1 - t_rel), 16'd0);
    read_burst(25'h100, t2);
    checkOutput("write to read spacing", 16'(t2 - t1), 16'd8);
    settle();
    check_read(t2, ramp(16'h1110), "write/read data");

    write_burst(25'h200, {8{16'hFFFF}}, SEL_ALL, t1);
    write_burst(25'h200, {8{16'hA5C3}}, {4{2'b01, 2'b10}}, t2);
    read_burst(25'h200, t3);
    settle();
    check_read(t3, {4{16'hFFC3, 16'hA5FF}}, "byte lanes");

    write_burst(25'h400, ramp(16'h4000), SEL_ALL, t1);
    write_burst(25'h410, ramp(16'h4100), SEL_ALL, t2);
    read_burst(25'h400, t3);
    write_burst(25'h420, ramp(16'h4200), SEL_ALL, t4);
    read_burst(25'h410, t5);
    settle();
    checkOutput("b2b write/write", 16'(t2 - t1), 16'd8);
    checkOutput("b2b write/read", 16'(t3 - t2), 16'd8);
    checkOutput("b2b read/write", 16'(t4 - t3), 16'd8);
    checkOutput("b2b write/read 2", 16'(t5 - t4), 16'd8);
    check_read(t3, ramp(16'h4000), "b2b read A");
    check_read(t5, ramp(16'h4100), "b2b read B");

    read_burst(25'h100 + 25'(1 << (MEM_DEPTH + 1)), t1);
    settle();
    check_read(t1, ramp(16'h1110), "alias");

    write_burst(25'h10E, ramp(16'h5550), SEL_ALL, t1);
    read_burst(25'h100, t2);
    settle();
    check_read(t2, ramp(16'h5550), "alignment");

    write_burst(25'h300, 128'h0, SEL_ALL, t1);
    lanes = ramp(16'h3330);
    request(1'b1, 25'h300, 2'b11, lanes[15:0], t2);
    for (int b = 1; b < 4; b++) begin
      next_cycle();
      applyStimulus(1'b0, 1'b0, 25'h0, 2'b11, lanes[16*b +: 16]);
      if (b == 3) sys_rst = 1'b1;
    end
    next_cycle();
    sys_rst = 1'b0;
    t_rel = cyc;
    read_burst(25'h300, t3);
    checkOutput("ack after mid-burst reset", 16'(t3 - t_rel), 16'd0);
    settle();
    if (t3 >= 0) checkOutput("do cleared by reset", do_at[t3], 16'h0000);
    check_read(t3, {80'h0, 16'h3332, 16'h3331, 16'h3330}, "reset mid-write");

    repeat (2) next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
